// File: rtl/reg_value_painter_pkg.sv
// Shared display constants, painter state encoding and character-code helpers
// for the register value painter.
package reg_value_painter_pkg;

  localparam int X_START_DEFAULT = 40;
  localparam int Y_START_DEFAULT = 40;
  localparam int CELL_PITCH      = 8;
  localparam int ROW_PITCH       = 10;

  localparam logic [8:0] COLOR_LABEL = 9'b000111000;
  localparam logic [8:0] COLOR_VALUE = 9'b111000000;
  localparam logic [8:0] COLOR_CLEAR = 9'b000000000;

  localparam logic [7:0] CODE_ZERO  = 8'd48;
  localparam logic [7:0] CODE_COLON = 8'd58;

  typedef enum logic [1:0] {
    CAPTURE,
    FULL,
    IDLE,
    PAINT
  } state_t;

  function automatic logic [7:0] hex_code(input logic [3:0] v);
    return (v < 4'd10) ? (CODE_ZERO + {4'd0, v}) : (8'd55 + {4'd0, v});
  endfunction

endpackage

// File: rtl/reg_value_painter_char_bitmap.sv
// 8x8 glyph ROM for '0'-'9', ':' and 'A'-'F'; line 0 is the top of the glyph,
// bit 7 of each line is the leftmost pixel.
module char_bitmap (
  input  logic [7:0] code,
  input  logic [2:0] line,
  output logic [7:0] bits
);

  logic [63:0] glyph;

  always_comb begin
    case (code)
      8'd48:   glyph = 64'h7CC6CEDEF6E67C00;
      8'd49:   glyph = 64'h307030303030FC00;
      8'd50:   glyph = 64'h78CC0C3860CCFC00;
      8'd51:   glyph = 64'h78CC0C380CCC7800;
      8'd52:   glyph = 64'h1C3C6CCCFE0C1E00;
      8'd53:   glyph = 64'hFCC0F80C0CCC7800;
      8'd54:   glyph = 64'h3860C0F8CCCC7800;
      8'd55:   glyph = 64'hFCCC0C1830303000;
      8'd56:   glyph = 64'h78CCCC78CCCC7800;
      8'd57:   glyph = 64'h78CCCC7C0C187000;
      8'd58:   glyph = 64'h0030300000303000;
      8'd65:   glyph = 64'h3078CCCCFCCCCC00;
      8'd66:   glyph = 64'hFC66667C6666FC00;
      8'd67:   glyph = 64'h3C66C0C0C0663C00;
      8'd68:   glyph = 64'hF86C6666666CF800;
      8'd69:   glyph = 64'hFE6268786862FE00;
      8'd70:   glyph = 64'hFE6268786860F000;
      default: glyph = 64'h0;
    endcase
  end

  // Line 0 lives in the top byte, so ~line selects the byte from the bottom.
  assign bits = glyph[{~line, 3'b000} +: 8];

endmodule

// File: rtl/reg_value_painter.sv
// Paints an 8-row "i:V" register table into a VGA frame buffer, one pixel per
// cycle: a full repaint after reset, then single value cells as registers change.
module reg_value_painter
  import reg_value_painter_pkg::*;
#(
  parameter int X_START = X_START_DEFAULT,
  parameter int Y_START = Y_START_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] R0,
  input  logic [3:0] R1,
  input  logic [3:0] R2,
  input  logic [3:0] R3,
  input  logic [3:0] R4,
  input  logic [3:0] R5,
  input  logic [3:0] R6,
  input  logic [3:0] R7,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [8:0] color,
  output logic       write,
  output logic       busy
);

  state_t          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [5:0]      px_q, px_d;
  logic [7:0][3:0] snap_q;
  logic [7:0][3:0] regs;
  logic            snap_load;
  logic            any_diff;
  logic [2:0]      diff_idx;
  logic [7:0]      cell_code;
  logic [7:0]      glyph_bits;
  logic [2:0]      bit_sel;

  assign regs = {R7, R6, R5, R4, R3, R2, R1, R0};

  // Descending scan so the lowest mismatching index is the one that sticks.
  always_comb begin
    any_diff = 1'b0;
    diff_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (regs[i] != snap_q[i]) begin
        any_diff = 1'b1;
        diff_idx = 3'(i);
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    px_d      = px_q;
    snap_load = 1'b0;
    case (state_q)
      CAPTURE: begin
        state_d = FULL;
        row_d   = '0;
        col_d   = '0;
        px_d    = '0;
      end
      FULL: begin
        px_d = px_q + 6'd1;
        if (px_q == 6'd63) begin
          if (col_q == 2'd2) begin
            col_d = '0;
            if (row_q == 3'd7) state_d = IDLE;
            else               row_d   = row_q + 3'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      IDLE: begin
        if (any_diff) begin
          state_d   = PAINT;
          row_d     = diff_idx;
          col_d     = 2'd2;
          px_d      = '0;
          snap_load = 1'b1;
        end
      end
      PAINT: begin
        px_d = px_q + 6'd1;
        if (px_q == 6'd63) state_d = IDLE;
      end
      default: state_d = CAPTURE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= CAPTURE;
      row_q   <= '0;
      col_q   <= '0;
      px_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      px_q    <= px_d;
    end
  end

  // NOTE: the snapshot has no reset value on purpose; CAPTURE always loads it
  // before anything reads it, so a reset term would only add logic.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      if (state_q == CAPTURE) snap_q <= regs;
      else if (snap_load)     snap_q[diff_idx] <= regs[diff_idx];
    end
  end

  always_comb begin
    case (col_q)
      2'd0:    cell_code = CODE_ZERO + {5'd0, row_q};
      2'd1:    cell_code = CODE_COLON;
      default: cell_code = hex_code(snap_q[row_q]);
    endcase
  end

  char_bitmap u_glyph (
    .code (cell_code),
    .line (px_q[5:3]),
    .bits (glyph_bits)
  );

  assign bit_sel = ~px_q[2:0];

  always_comb begin
    write = (state_q == FULL) || (state_q == PAINT);
    busy  = (state_q != IDLE);
    x     = '0;
    y     = '0;
    color = COLOR_CLEAR;
    if (write) begin
      x = 10'(X_START + CELL_PITCH * int'(col_q) + int'(px_q[2:0]));
      y = 9'(Y_START + ROW_PITCH * int'(row_q) + int'(px_q[5:3]));
      if (glyph_bits[bit_sel]) color = (col_q == 2'd2) ? COLOR_VALUE : COLOR_LABEL;
    end
  end

endmodule

// File: tb/tb_reg_value_painter.sv
// Self-checking bench for reg_value_painter: directed scenarios plus a random
// register-change phase checked pixel-by-pixel against a table-level model.
module tb_reg_value_painter;

  localparam int          X0    = 40;
  localparam int          Y0    = 40;
  localparam logic [8:0]  GREEN = 9'b000111000;
  localparam logic [8:0]  RED   = 9'b111000000;

  typedef struct {
    int at;
    int idx;
    int val;
  } poke_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] r [8];
  logic [9:0] x;
  logic [8:0] y;
  logic [8:0] color;
  logic       write;
  logic       busy;

  int    checks = 0;
  int    failures = 0;
  int    model_snap [8];
  poke_t poke_q [$];

  always #5 clk = ~clk;

  reg_value_painter dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .R0       (r[0]),
    .R1       (r[1]),
    .R2       (r[2]),
    .R3       (r[3]),
    .R4       (r[4]),
    .R5       (r[5]),
    .R6       (r[6]),
    .R7       (r[7]),
    .x        (x),
    .y        (y),
    .color    (color),
    .write    (write),
    .busy     (busy)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference font: index 0..15 = hex digits, 16 = ':'; top line in the MSB byte.
  function automatic logic [63:0] font(input int ch);
    case (ch)
      0:  return 64'h7CC6CEDEF6E67C00;
      1:  return 64'h307030303030FC00;
      2:  return 64'h78CC0C3860CCFC00;
      3:  return 64'h78CC0C380CCC7800;
      4:  return 64'h1C3C6CCCFE0C1E00;
      5:  return 64'hFCC0F80C0CCC7800;
      6:  return 64'h3860C0F8CCCC7800;
      7:  return 64'hFCCC0C1830303000;
      8:  return 64'h78CCCC78CCCC7800;
      9:  return 64'h78CCCC7C0C187000;
      10: return 64'h3078CCCCFCCCCC00;
      11: return 64'hFC66667C6666FC00;
      12: return 64'h3C66C0C0C0663C00;
      13: return 64'hF86C6666666CF800;
      14: return 64'hFE6268786862FE00;
      15: return 64'hFE6268786860F000;
      16: return 64'h0030300000303000;
      default: return 64'h0;
    endcase
  endfunction

  // Pixel p = 8*prow + pcol of cell (row, col); pixel p is bit 63-p of the glyph.
  function automatic logic [8:0] exp_color(input int row, input int col, input int val, input int p);
    logic [63:0] g;
    g = font((col == 0) ? row : (col == 1) ? 16 : val);
    if (!g[63 - p]) return 9'd0;
    return (col == 2) ? RED : GREEN;
  endfunction

  function automatic int lowest_mismatch();
    for (int i = 0; i < 8; i++)
      if (int'(r[i]) != model_snap[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge showing the cell's first pixel; leaves at its last checked pixel.
  task automatic check_cell(input int row, input int col, input int val, input int n_px);
    for (int p = 0; p < n_px; p++) begin
      if (p > 0) @(negedge clk);
      check("cell_write", write, 1);
      check("cell_busy", busy, 1);
      check("cell_x", x, X0 + 8 * col + p % 8);
      check("cell_y", y, Y0 + 10 * row + p / 8);
      check("cell_color", color, exp_color(row, col, val, p));
      if (row == 0 && col == 0 && p == 0) check("pix_40_40_black", color, 0);
      if (row == 0 && col == 0 && p == 9) check("pix_41_41_green", color, GREEN);
      if (row == 5 && col == 2 && val == 10 && p == 9) check("pix_57_91_red", color, RED);
      if (row == 5 && col == 2 && val == 10 && p == 0) check("pix_56_90_black", color, 0);
      if (poke_q.size() > 0 && poke_q[0].at == p) begin
        r[poke_q[0].idx] = 4'(poke_q[0].val);
        poke_q.delete(0);
      end
    end
  endtask

  task automatic wait_write(input int bound);
    int n = 0;
    while (write !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_write", write, 1);
  endtask

  task automatic full_pass();
    for (int i = 0; i < 8; i++) model_snap[i] = int'(r[i]);
    for (int row = 0; row < 8; row++) begin
      for (int col = 0; col < 3; col++) begin
        if (!(row == 0 && col == 0)) @(negedge clk);
        check_cell(row, col, model_snap[row], 64);
      end
    end
    @(negedge clk);
    check("full_done_write", write, 0);
    check("full_done_busy", busy, 0);
  endtask

  // Called at an IDLE negedge where `row` is the lowest changed register.
  task automatic service(input int row);
    model_snap[row] = int'(r[row]);
    @(negedge clk);
    check_cell(row, 2, model_snap[row], 64);
    @(negedge clk);
    check("after_paint_write", write, 0);
    check("after_paint_busy", busy, 0);
  endtask

  initial begin
    int lo;
    for (int i = 0; i < 8; i++) r[i] = 4'(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_write", write, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", color, 0);
    check("rst_busy", busy, 1);

    // Full repaint after release, then a quiet stretch
    reset = 1'b0;
    wait_write(4);
    full_pass();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check("quiet_write", write, 0);
      check("quiet_busy", busy, 0);
    end

    // Single-cell repaints of R5
    r[5] = 4'h4;
    service(5);
    r[5] = 4'hA;
    service(5);

    // Two simultaneous changes, lowest first with one idle cycle between
    r[2] = 4'h9;
    r[6] = 4'hC;
    service(2);
    service(6);

    // Glitch on R1 during a pass is invisible; a held change is repainted
    r[1] = 4'h3;
    service(1);
    r[2] = 4'h3;
    poke_q.push_back('{at: 10, idx: 1, val: 7});
    poke_q.push_back('{at: 20, idx: 1, val: 3});
    service(2);
    @(negedge clk);
    check("no_glitch_repaint", write, 0);
    r[2] = 4'h4;
    poke_q.push_back('{at: 10, idx: 1, val: 7});
    service(2);
    service(1);

    // Random register activity, including changes landing mid-pass
    for (int it = 0; it < 20; it++) begin
      int nchg = $urandom_range(1, 3);
      for (int k = 0; k < nchg; k++) r[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
      for (int guard = 0; guard < 24; guard++) begin
        lo = lowest_mismatch();
        if (lo < 0) break;
        if ($urandom_range(0, 1) == 1)
          poke_q.push_back('{at: $urandom_range(0, 63), idx: $urandom_range(0, 7), val: $urandom_range(0, 15)});
        service(lo);
      end
      @(negedge clk);
      check("rand_settled_write", write, 0);
      check("rand_settled_busy", busy, 0);
    end

    // Reset in the middle of a PAINT pass
    r[0] = r[0] + 4'd1;
    model_snap[0] = int'(r[0]);
    @(negedge clk);
    check_cell(0, 2, model_snap[0], 31);
    reset = 1'b1;
    @(negedge clk);
    check("abort_write", write, 0);
    check("abort_x", x, 0);
    check("abort_busy", busy, 1);
    @(negedge clk);
    check("abort_hold_write", write, 0);
    reset = 1'b0;
    wait_write(4);
    full_pass();
    repeat (5) @(negedge clk);
    check("final_idle_write", write, 0);
    check("final_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
